// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the registered ALU.
package alu_pkg;

  localparam int unsigned OPW   = 5;
  localparam int unsigned FLAGW = 4;

  localparam logic [OPW-1:0] NOP  = 5'd0;
  localparam logic [OPW-1:0] ANDS = 5'd1;
  localparam logic [OPW-1:0] ORRS = 5'd2;
  localparam logic [OPW-1:0] MVNS = 5'd3;
  localparam logic [OPW-1:0] EORS = 5'd4;
  localparam logic [OPW-1:0] ADCS = 5'd5;
  localparam logic [OPW-1:0] ADDS = 5'd6;
  localparam logic [OPW-1:0] SBCS = 5'd7;
  localparam logic [OPW-1:0] SUB  = 5'd8;
  localparam logic [OPW-1:0] MULS = 5'd9;
  localparam logic [OPW-1:0] LSRS = 5'd10;
  localparam logic [OPW-1:0] LSLS = 5'd11;
  localparam logic [OPW-1:0] ASR  = 5'd12;
  localparam logic [OPW-1:0] ROR  = 5'd13;
  localparam logic [OPW-1:0] UXTB = 5'd14;
  localparam logic [OPW-1:0] UXTH = 5'd15;
  localparam logic [OPW-1:0] SXTB = 5'd16;
  localparam logic [OPW-1:0] SXTH = 5'd17;
  localparam logic [OPW-1:0] CMP  = 5'd18;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for LSRS/LSLS/ASR/ROR with carry-out.
// carry_valid_c is low when the carry flag must be left unchanged.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] value,
  input  logic [7:0]       amount,
  output logic [WIDTH-1:0] result_c,
  output logic             carry_c,
  output logic             carry_valid_c
);

  localparam int unsigned AW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] rot_dbl;

  // Rotation by doubling the word and shifting the concatenation.
  always_comb begin
    rot_dbl = {value, value} >> amount[AW-1:0];
  end

  // Shift result and last-bit-out selection, including out-of-range amounts.
  always_comb begin
    result_c      = value;
    carry_c       = 1'b0;
    carry_valid_c = 1'b0;
    case (op)
      LSRS: begin
        if (amount == 8'd0) begin
          result_c = value;
        end else if (amount < 8'(WIDTH)) begin
          result_c      = value >> amount[AW-1:0];
          carry_c       = value[AW'(amount - 8'd1)];
          carry_valid_c = 1'b1;
        end else begin
          result_c      = '0;
          carry_c       = (amount == 8'(WIDTH)) ? value[WIDTH-1] : 1'b0;
          carry_valid_c = 1'b1;
        end
      end
      LSLS: begin
        if (amount == 8'd0) begin
          result_c = value;
        end else if (amount < 8'(WIDTH)) begin
          result_c      = value << amount[AW-1:0];
          carry_c       = value[AW'(8'(WIDTH) - amount)];
          carry_valid_c = 1'b1;
        end else begin
          result_c      = '0;
          carry_c       = (amount == 8'(WIDTH)) ? value[0] : 1'b0;
          carry_valid_c = 1'b1;
        end
      end
      ASR: begin
        if (amount == 8'd0) begin
          result_c = value;
        end else if (amount < 8'(WIDTH)) begin
          result_c      = $signed(value) >>> amount[AW-1:0];
          carry_c       = value[AW'(amount - 8'd1)];
          carry_valid_c = 1'b1;
        end else begin
          result_c      = {WIDTH{value[WIDTH-1]}};
          carry_c       = value[WIDTH-1];
          carry_valid_c = 1'b1;
        end
      end
      ROR: begin
        result_c      = rot_dbl[WIDTH-1:0];
        carry_c       = rot_dbl[WIDTH-1];
        carry_valid_c = (amount != 8'd0);
      end
      default: begin
        result_c = value;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU with NZCV flags; stored C feeds ADCS/SBCS.
// Define ALU_MUL_EN to build the multiplier; otherwise MULS acts as NOP.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   instruction,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] result,
  output logic [FLAGW-1:0] flags
);

  logic             is_sub;
  logic             cin;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] sh_result;
  logic             sh_carry;
  logic             sh_carry_valid;
  logic [WIDTH-1:0] next_result;
  logic [FLAGW-1:0] next_flags;
  logic             upd_nz;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] product;
  assign product = num1 * num2;
`endif

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .op            (instruction),
    .value         (num1),
    .amount        (num2[7:0]),
    .result_c      (sh_result),
    .carry_c       (sh_carry),
    .carry_valid_c (sh_carry_valid)
  );

  // Shared adder: subtraction is A + ~B + carry-in.
  always_comb begin
    is_sub = instruction inside {SBCS, SUB, CMP};
    opb    = is_sub ? ~num2 : num2;
    case (instruction)
      ADCS, SBCS: cin = flags[FLAG_C];
      SUB, CMP:   cin = 1'b1;
      default:    cin = 1'b0;
    endcase
    sum = {1'b0, num1} + {1'b0, opb} + (WIDTH+1)'(cin);
    ovf = (num1[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != num1[WIDTH-1]);
  end

  // Next result/flags per opcode; unlisted opcodes hold both.
  always_comb begin
    next_result = result;
    next_flags  = flags;
    upd_nz      = 1'b0;
    case (instruction)
      ANDS: begin next_result = num1 & num2; upd_nz = 1'b1; end
      ORRS: begin next_result = num1 | num2; upd_nz = 1'b1; end
      MVNS: begin next_result = ~num1;       upd_nz = 1'b1; end
      EORS: begin next_result = num1 ^ num2; upd_nz = 1'b1; end
      ADCS, ADDS, SBCS, SUB: begin
        next_result        = sum[WIDTH-1:0];
        upd_nz             = 1'b1;
        next_flags[FLAG_C] = sum[WIDTH];
        next_flags[FLAG_V] = ovf;
      end
`ifdef ALU_MUL_EN
      MULS: begin next_result = product; upd_nz = 1'b1; end
`endif
      LSRS, LSLS, ASR, ROR: begin
        next_result = sh_result;
        upd_nz      = 1'b1;
        if (sh_carry_valid) next_flags[FLAG_C] = sh_carry;
      end
      UXTB: next_result = {{(WIDTH-8){1'b0}}, num1[7:0]};
      UXTH: next_result = {{(WIDTH-16){1'b0}}, num1[15:0]};
      SXTB: next_result = {{(WIDTH-8){num1[7]}}, num1[7:0]};
      SXTH: next_result = {{(WIDTH-16){num1[15]}}, num1[15:0]};
      CMP: begin
        next_flags[FLAG_N] = sum[WIDTH-1];
        next_flags[FLAG_Z] = (sum[WIDTH-1:0] == '0);
        next_flags[FLAG_C] = sum[WIDTH];
        next_flags[FLAG_V] = ovf;
      end
      default: ;
    endcase
    if (upd_nz) begin
      next_flags[FLAG_N] = next_result[WIDTH-1];
      next_flags[FLAG_Z] = (next_result == '0);
    end
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else begin
      result <= next_result;
      flags  <= next_flags;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed steps plus randomized vectors
// checked against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [4:0]  instruction;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] result;
  logic [3:0]  flags;

  int vectors;
  int errors;

  logic [31:0] m_res;
  logic [3:0]  m_flags;

  alu dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .num1        (num1),
    .num2        (num2),
    .result      (result),
    .flags       (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: updates m_res/m_flags from plain arithmetic.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [3:0]  f;
    logic        nz;
    logic        c_in;
    logic        c;
    logic [31:0] bb;
    logic [63:0] us;
    longint      sa, sb, ss;
    int          n;
    byte         b8;
    shortint     h16;
    r  = m_res;
    f  = m_flags;
    nz = 1'b0;
    case (op)
      1: begin r = a & b; nz = 1'b1; end
      2: begin r = a | b; nz = 1'b1; end
      3: begin r = ~a;    nz = 1'b1; end
      4: begin r = a ^ b; nz = 1'b1; end
      5, 6, 7, 8, 18: begin
        c_in = (op == 5 || op == 7) ? m_flags[1] : (op == 6 ? 1'b0 : 1'b1);
        bb   = (op == 5 || op == 6) ? b : ~b;
        us   = 64'(a) + 64'(bb) + 64'(c_in);
        sa   = longint'($signed(a));
        sb   = longint'($signed(bb));
        ss   = sa + sb + longint'(c_in);
        f[1] = us[32];
        f[0] = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        if (op == 18) begin
          f[3] = us[31];
          f[2] = (us[31:0] == 32'd0);
        end else begin
          r  = us[31:0];
          nz = 1'b1;
        end
      end
      9: begin
`ifdef ALU_MUL_EN
        r  = a * b;
        nz = 1'b1;
`endif
      end
      10, 11, 12: begin
        n = int'(b[7:0]);
        r = a;
        c = 1'b0;
        for (int i = 0; i < n; i++) begin
          if (op == 11) begin
            c = r[31];
            r = r << 1;
          end else begin
            c = r[0];
            r = (op == 12) ? {r[31], r[31:1]} : {1'b0, r[31:1]};
          end
        end
        if (n != 0) f[1] = c;
        nz = 1'b1;
      end
      13: begin
        r = a;
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[0], r[31:1]};
        if (b[7:0] != 8'd0) f[1] = r[31];
        nz = 1'b1;
      end
      14: r = a & 32'h0000_00FF;
      15: r = a & 32'h0000_FFFF;
      16: begin b8 = a[7:0];   r = 32'(int'(b8));  end
      17: begin h16 = a[15:0]; r = 32'(int'(h16)); end
      default: ;
    endcase
    if (nz) begin
      f[3] = r[31];
      f[2] = (r == 32'd0);
    end
    m_res   = r;
    m_flags = f;
  endtask

  task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instruction = op;
    num1        = a;
    num2        = b;
    @(posedge clk);
    #1;
    model(op, a, b);
    check($sformatf("op%0d_result", op), result, m_res);
    check($sformatf("op%0d_flags", op), 32'(flags), 32'(m_flags));
  endtask

  initial begin
    logic [31:0] held;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    vectors     = 0;
    errors      = 0;
    m_res       = '0;
    m_flags     = '0;
    rst         = 1'b1;
    instruction = 5'd0;
    num1        = '0;
    num2        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Logic ops
    step(5'd1, 32'd15, 32'd10);           check("ands_lit", result, 32'd10);
    step(5'd2, 32'd500, 32'd5);           check("orrs_lit", result, 32'd501);
    step(5'd3, 32'hFFFF_FFA0, 32'd0);     check("mvns_lit", result, 32'd95);
    step(5'd4, 32'd295, 32'd426);         check("eors_lit", result, 32'd141);
    check("eors_nz", 32'(flags[3:2]), 32'd0);

    // Add with carry chain
    step(5'd6, 32'd51526, 32'hFFFF_FFA0); check("adds_lit", result, 32'd51430);
    check("adds_cv", 32'(flags[1:0]), 32'b10);
    step(5'd5, 32'd9, 32'd1);             check("adcs_lit", result, 32'd11);
    step(5'd6, 32'h7FFF_FFFF, 32'd1);     check("adds_ovf", result, 32'h8000_0000);
    check("adds_ovf_nv", {30'd0, flags[3], flags[0]}, 32'b11);

    // Subtract and compare
    step(5'd8, 32'd16, 32'd4);            check("sub_lit", result, 32'd12);
    check("sub_c", 32'(flags[1]), 32'd1);
    step(5'd7, 32'd50, 32'd4);            check("sbcs_lit", result, 32'd46);
    step(5'd18, 32'd4, 32'd4);            check("cmp_hold", result, 32'd46);
    check("cmp_zc", 32'(flags[2:1]), 32'b11);
    step(5'd8, 32'd0, 32'd1);             check("sub_neg", result, 32'hFFFF_FFFF);
    check("sub_neg_nc", {30'd0, flags[3], flags[1]}, 32'b10);

    // Multiply and shifts
    step(5'd9, 32'd5, 32'd4);
`ifdef ALU_MUL_EN
    check("muls_lit", result, 32'd20);
`else
    check("muls_off", result, 32'hFFFF_FFFF);
`endif
    step(5'd11, 32'd13, 32'd3);           check("lsls_lit", result, 32'd104);
    step(5'd10, 32'd13, 32'd3);           check("lsrs_lit", result, 32'd1);
    check("lsrs_c", 32'(flags[1]), 32'd1);
    step(5'd12, 32'd205, 32'd3);          check("asr_lit", result, 32'd25);
    step(5'd12, 32'h8000_0000, 32'd40);   check("asr_big", result, 32'hFFFF_FFFF);
    step(5'd13, 32'd1, 32'd1);            check("ror_lit", result, 32'h8000_0000);
    check("ror_c", 32'(flags[1]), 32'd1);
    step(5'd10, 32'h8000_0001, 32'd32);
    step(5'd11, 32'h8000_0001, 32'd32);
    step(5'd11, 32'h8000_0001, 32'd33);
    step(5'd10, 32'h1234_5678, 32'd0);

    // Extends leave flags unchanged
    step(5'd14, 32'd490, 32'd0);          check("uxtb_lit", result, 32'd234);
    step(5'd15, 32'd56623, 32'd0);        check("uxth_lit", result, 32'd56623);
    step(5'd16, 32'd5950485, 32'd0);      check("sxtb_lit", result, 32'd21);
    step(5'd17, 32'd5950485, 32'd0);      check("sxth_lit", result, 32'hFFFF_CC15);

    // Hold on NOP and unused opcodes
    held = result;
    for (int i = 0; i < 3; i++) begin
      step(5'd0, 32'hDEAD_BEEF, 32'h1);
      step(5'd25, 32'hDEAD_BEEF, 32'h1);
    end
    check("hold_lit", result, held);

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_result", result, 32'd0);
    check("async_rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    m_res   = '0;
    m_flags = '0;

    // Randomized vectors with boundary-biased shift amounts
    for (int i = 0; i < 400; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'd1;
        2: rb = 32'd31;
        3: rb = 32'd32;
        4: rb = 32'd33;
        5: rb = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h7FFF_FFFF;
      step(rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
